// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU.
//   op_t    : 3-bit operation code presented on the op port
//   state_t : control FSM state, also exported on the debug port
package alu_pkg;

  // The reserved encoding produces a zero result with only flag_z set.
  localparam logic [2:0] OP_RESERVED = 3'b111;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = OP_RESERVED
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add signed multiplier, one partial product per clock.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset (aborts a run)
//   start          : load a/b and begin; ignored bits of a/b afterwards
//   a, b           : signed operands, sampled only on the start edge
//   done           : high in the cycle whose rising edge performs the last
//                    step; product is valid in that same cycle
//   product        : full 2*WIDTH-bit signed product (combinational)
// A run takes WIDTH steps after the start edge.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // Magnitudes are unsigned WIDTH-bit values, so |-2^(WIDTH-1)| = 2^(WIDTH-1)
  // is representable; the multiplicand then widens to 2*WIDTH bits.
  always_comb begin
    a_mag    = a[WIDTH-1] ? (~a + 1'b1) : a;
    b_mag    = b[WIDTH-1] ? (~b + 1'b1) : b;
    acc_next = acc + (mplr[0] ? mcand : '0);
    product  = neg ? (~acc_next + 1'b1) : acc_next;
    done     = busy && (cnt == LAST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      neg   <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      neg   <= a[WIDTH-1] ^ b[WIDTH-1];
      cnt   <= '0;
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a_mag};
      mplr  <= b_mag;
    end else if (busy) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Sequential N-bit ALU with valid/ready operand and result handshakes.
// Ports:
//   clock, reset_n     : clock and asynchronous active-low reset
//   in_valid/in_ready  : operand handshake; a/b/op captured when both high
//   a, b, op           : signed operands and alu_pkg::op_t code
//   out_valid/out_ready: result handshake; result/flags held while stalled
//   result             : registered result
//   flag_o/c/z         : signed overflow, carry/borrow, zero
//   state_dbg          : current FSM state (alu_pkg::state_t encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state (and reset), never on out_ready,
// so a single-cycle op occupies the block for at least two cycles.
module alu_seq_n
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_o,
  output logic             flag_c,
  output logic             flag_z,
  output logic [1:0]       state_dbg
);

  state_t state;
  op_t    op_in;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_o;
  logic               alu_c;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_ovf;

  assign op_in     = op_t'(op);
  assign in_ready  = (state == IDLE) && reset_n;
  assign out_valid = (state == DONE);
  assign state_dbg = state;
  assign mul_start = (state == IDLE) && in_valid && (op_in == OP_MUL);

  // The product fits in WIDTH bits only when its upper WIDTH+1 bits are
  // all copies of the sign.
  assign mul_ovf = ~((&mul_prod[2*WIDTH-1:WIDTH-1]) |
                     ~(|mul_prod[2*WIDTH-1:WIDTH-1]));

  // Single-cycle datapath. The extra top bit of the unsigned add/sub holds
  // the carry-out or the borrow (a < b unsigned).
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    alu_res  = '0;
    alu_o    = 1'b0;
    alu_c    = 1'b0;
    case (op_in)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_ADD: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_o   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ext[WIDTH-1:0];
        alu_c   = diff_ext[WIDTH];
        alu_o   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      // MUL goes through the multiplier; the reserved code yields zero.
      default: alu_res = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      result <= '0;
      flag_o <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op_in == OP_MUL) begin
              state <= MUL;
            end else begin
              result <= alu_res;
              flag_o <= alu_o;
              flag_c <= alu_c;
              flag_z <= (alu_res == '0);
              state  <= DONE;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            result <= mul_prod[WIDTH-1:0];
            flag_o <= mul_ovf;
            flag_c <= 1'b0;
            flag_z <= (mul_prod[WIDTH-1:0] == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Bench for alu_seq_n at WIDTH = 8. Expected {result, o, c, z} words are
// pushed when an operation is sent and popped when a result handshake occurs.
module tb_alu_seq_n;

  localparam int W = 8;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         flag_o;
  logic         flag_c;
  logic         flag_z;
  logic [1:0]   state_dbg;

  int errors = 0;
  int checks = 0;

  logic [W+2:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  alu_seq_n #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_o    (flag_o),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic logic [W+2:0] model(input logic [2:0] mop,
                                         input logic [W-1:0] ma,
                                         input logic [W-1:0] mb);
    int sa, sb, ua, ub, full, lo, hi;
    logic [W-1:0] r;
    logic o, c;
    sa = $signed(ma);
    sb = $signed(mb);
    ua = ma;
    ub = mb;
    lo = -(1 << (W - 1));
    hi = (1 << (W - 1)) - 1;
    r = '0; o = 1'b0; c = 1'b0; full = 0;
    case (mop)
      3'b000: r = ma & mb;
      3'b001: r = ma | mb;
      3'b100: r = ma ^ mb;
      3'b010: begin
        full = ua + ub;
        r = full[W-1:0];
        c = full[W];
        o = ((sa + sb) < lo) || ((sa + sb) > hi);
      end
      3'b011: begin
        full = sa - sb;
        r = full[W-1:0];
        c = (ua < ub);
        o = (full < lo) || (full > hi);
      end
      3'b101: r = (sa < sb) ? 1 : 0;
      3'b110: begin
        full = sa * sb;
        r = full[W-1:0];
        o = (full < lo) || (full > hi);
      end
      default: r = '0;
    endcase
    return {r, o, c, (r == '0)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      logic [W+2:0] got;
      logic [W+2:0] want;
      got = {result, flag_o, flag_c, flag_z};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got %h, required no output", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard: got {res,o,c,z}=%h_%b%b%b required %h_%b%b%b",
                   got[W+2:3], got[2], got[1], got[0],
                   want[W+2:3], want[2], want[1], want[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for in_ready, presents one op, returns #1 after the accept edge.
  task automatic send(input logic [2:0] sop, input logic [W-1:0] sa, input logic [W-1:0] sb);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    op = sop; a = sa; b = sb;
    in_valid = 1'b1;
    exp_q.push_back(model(sop, sa, sb));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, stalls for `hold` cycles, then lets the result go.
  task automatic drain(input int hold);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: out_valid=%b required 1", out_valid);
    end
    out_ready = 1'b0;
    repeat (hold) begin @(posedge clock); #1; end
    out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({in_ready, out_valid, result, flag_o, flag_c, flag_z} !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h flags=%b%b%b required all 0",
               in_ready, out_valid, result, flag_o, flag_c, flag_z);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b state=%0d required 1/0", in_ready, state_dbg);
    end
  endtask

  task automatic test_add();
    send(3'b010, 8'd100, 8'd50);
    checks++;
    if (out_valid !== 1'b1 || result !== 8'h96 || {flag_o, flag_c, flag_z} !== 3'b100) begin
      errors++;
      $display("FAIL add_latency: out_valid=%b result=%h ocz=%b%b%b required 1/96/100",
               out_valid, result, flag_o, flag_c, flag_z);
    end
    drain(0);
  endtask

  task automatic test_sub();
    send(3'b011, 8'h80, 8'd1);
    checks++;
    if (result !== 8'h7F || {flag_o, flag_c} !== 2'b10) begin
      errors++;
      $display("FAIL sub_ovf: result=%h oc=%b%b required 7f/10", result, flag_o, flag_c);
    end
    drain(0);
    send(3'b011, 8'd3, 8'd5);
    checks++;
    if (result !== 8'hFE || {flag_o, flag_c} !== 2'b01) begin
      errors++;
      $display("FAIL sub_borrow: result=%h oc=%b%b required fe/01", result, flag_o, flag_c);
    end
    drain(0);
  endtask

  task automatic test_mul();
    int edges;
    send(3'b110, 8'hF9, 8'd9);
    edges = 1;
    while (!out_valid && edges < 50) begin
      @(posedge clock); #1;
      edges++;
    end
    checks++;
    if (edges !== W + 1) begin
      errors++;
      $display("FAIL mul_latency: edges=%0d required %0d", edges, W + 1);
    end
    checks++;
    if (result !== 8'hC1 || flag_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_neg: result=%h o=%b required c1/0", result, flag_o);
    end
    drain(0);
    send(3'b110, 8'd16, 8'd16);
    drain(2);
    checks++;
    if (result !== 8'h00 || flag_o !== 1'b1 || flag_z !== 1'b1) begin
      errors++;
      $display("FAIL mul_ovf: result=%h o=%b z=%b required 00/1/1", result, flag_o, flag_z);
    end
    send(3'b110, 8'h80, 8'h80);
    drain(0);
    send(3'b110, 8'h80, 8'hFF);
    drain(0);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(3'b010, 8'd1, 8'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op = 3'($urandom_range(0, 7));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      @(posedge clock); #1;
      checks++;
      if (result !== 8'h02 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold: result=%h in_ready=%b out_valid=%b required 02/0/1",
                 result, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    send(3'b110, 8'd7, 8'd11);
    repeat (2) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_abort: out_valid=%b result=%h in_ready=%b state=%0d required 0/00/0/0",
               out_valid, result, in_ready, state_dbg);
    end
    #2;
    reset_n = 1'b1;
    repeat (12) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_result: out_valid=%b required 0", out_valid);
      end
    end
    send(3'b000, 8'hF0, 8'h3C);
    checks++;
    if (result !== 8'h30 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_and: result=%h out_valid=%b required 30/1", result, out_valid);
    end
    drain(0);
  endtask

  task automatic test_slt_rsv();
    send(3'b101, 8'hFF, 8'd1);
    checks++;
    if (result !== 8'h01 || flag_z !== 1'b0) begin
      errors++;
      $display("FAIL slt_true: result=%h z=%b required 01/0", result, flag_z);
    end
    drain(0);
    send(3'b101, 8'd1, 8'hFF);
    checks++;
    if (result !== 8'h00 || flag_z !== 1'b1) begin
      errors++;
      $display("FAIL slt_false: result=%h z=%b required 00/1", result, flag_z);
    end
    drain(0);
    send(3'b111, 8'h5A, 8'hA5);
    checks++;
    if (result !== 8'h00 || {flag_o, flag_c, flag_z} !== 3'b001) begin
      errors++;
      $display("FAIL reserved: result=%h ocz=%b%b%b required 00/001", result, flag_o, flag_c, flag_z);
    end
    drain(0);
    send(3'b001, 8'h0F, 8'h30);
    drain(0);
    send(3'b100, 8'hFF, 8'h0F);
    drain(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      drain($urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_slt_rsv();
    test_random();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pending results, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
